rr_req_concentrator: RTL
========================

Name: rr_req_concentrator

Overview:
- Multi-port packet concentrator sitting directly upstream of the round-robin arbiter; it also consumes the arbiter's outputs.
- Per port, it buffers one beat in a holding register and presents the holding-valid vector to the arbiter as requests.
- It uses the arbiter's grant to forward the winning port's beats into a 2-entry output FIFO.
- It locks onto the granted port until the packet's last beat, and pulses arb_round once per granted packet.

Parameters:
- PORT_NUM, 16, number of requesting ports (>=2).
- DATA_WIDTH, 32, payload width per beat.
- PORT_W, $clog2(PORT_NUM), port index width (derived, do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  PORT_NUM  per-port beat valid
- in_last  in  PORT_NUM  per-port last-beat-of-packet flag
- in_data  in  PORT_NUM*DATA_WIDTH  per-port payload; port i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- in_rdy  out  PORT_NUM  per-port ready
- arb_req  out  PORT_NUM  request vector to arbiter
- arb_gnt  in  PORT_NUM  one-hot grant from arbiter (combinational from arb_req)
- arb_port  in  PORT_W  binary index of arb_gnt
- arb_round  out  1  pointer-update strobe to arbiter
- out_vld  out  1  output beat valid
- out_last  out  1  output last-beat flag
- out_port  out  PORT_W  source port of output beat
- out_data  out  DATA_WIDTH  output payload
- out_rdy  in  1  downstream ready
- busy  out  1  high when state is LOCK or any holding register or FIFO entry is valid

Behaviour:
- Reset (async, rst_n=0):
  - hold_vld all 0; FIFO empty; state=ARB; lock_port=0.
  - Outputs: out_vld=0, out_last=0, out_port=0, out_data=0, arb_round=0, busy=0.
  - in_rdy all 1 after reset (holding registers empty).
- Holding register per port (hold_vld/hold_last/hold_data):
  - in_rdy[i] = ~hold_vld[i] | take[i].
  - Load when in_vld[i] & in_rdy[i].
  - take[i] and a load in the same cycle: new beat replaces the old one; hold_vld stays 1.
  - take[i] with no load: hold_vld[i] clears.
- arb_req = hold_vld (registered source; no combinational path from in_vld).
- fifo_ok = FIFO count < 2, using the registered count; pop in the same cycle does not count.
- State ARB:
  - sel = arb_port.
  - take[sel]=1 when |hold_vld & fifo_ok.
  - arb_round = that same take (exactly one-cycle pulse per granted packet).
  - If the taken beat has last=0: next state LOCK, lock_port<=sel.
  - If the taken beat has last=1 (single-beat packet): stay in ARB.
  - arb_gnt is checked against arb_port only by assertion.
- State LOCK:
  - arb_gnt/arb_port ignored; arb_round=0.
  - take[lock_port]=1 when hold_vld[lock_port] & fifo_ok.
  - Taken beat with last=1: next state ARB.
  - Other ports keep requesting but are never taken.
- Output FIFO:
  - Depth 2; entry = {port, last, data}.
  - Push on any take; pop on out_vld & out_rdy.
  - Simultaneous push and pop at count 2 is not possible: push is blocked by fifo_ok.
  - Simultaneous push and pop at count 1 leaves count 1.
  - out_* driven from the head entry; out_vld = count!=0.
  - out_* hold stable while out_vld & ~out_rdy.
- Latency: beat accepted at cycle N reaches out_vld at cycle N+2 at the earliest (hold register, then FIFO head).
- Throughput: 1 beat/cycle sustained with out_rdy=1.
- Packet integrity: beats of different ports never interleave on the output.
- Reset mid-packet: all state discarded; the partial packet is not completed.

Test Plan:
- Single beat: port 3 sends data=0xA5A5_0003 with last=1, out_rdy=1 → out_vld at +2 cycles with out_port=3, out_data=0xA5A5_0003, out_last=1; arb_round pulses exactly once; state stays ARB.
- Fairness: ports 0, 5, 15 each send 4 single-beat packets back-to-back, out_rdy=1 → out_port sequence 0,5,15,0,5,15,… (rotation per arbiter pointer); 12 beats total; 12 arb_round pulses.
- Packet lock: port 2 sends a 4-beat packet while port 1 requests continuously → 4 consecutive port-2 beats (last only on 4th), then port 1; arb_round pulses only at the port-2 grant and the port-1 grant.
- Backpressure: out_rdy=0 for 10 cycles under a port-7 stream → FIFO fills to 2; in_rdy[7] drops after the hold register fills; out_data stable; on out_rdy=1 no beat is lost or duplicated (scoreboard checks order).
- Same-cycle refill: port 4 drives in_vld=1 every cycle with incrementing data, out_rdy=1 → in_rdy[4] stays 1; output data increments by 1 each cycle after the initial 2-cycle latency.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet from port 9 → out_vld=0, busy=0, in_rdy all 1; after release, a new port-0 single-beat packet is granted normally.

Source files
------------

// File: rtl/rr_req_concentrator.sv
// Per-port beat holding registers feeding an external round-robin arbiter; the
// granted port is locked until its last beat and forwarded into a 2-entry FIFO.
module rr_req_concentrator #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PORT_W     = $clog2(PORT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORT_NUM-1:0]            in_vld,
  input  logic [PORT_NUM-1:0]            in_last,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] in_data,
  output logic [PORT_NUM-1:0]            in_rdy,
  output logic [PORT_NUM-1:0]            arb_req,
  input  logic [PORT_NUM-1:0]            arb_gnt,
  input  logic [PORT_W-1:0]              arb_port,
  output logic                           arb_round,
  output logic                           out_vld,
  output logic                           out_last,
  output logic [PORT_W-1:0]              out_port,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_rdy,
  output logic                           busy
);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t                state_q, state_d;
  logic [PORT_W-1:0]     lock_port_q, lock_port_d;

  logic [PORT_NUM-1:0]   hold_vld_q, hold_vld_d;
  logic [PORT_NUM-1:0]   hold_last_q, hold_last_d;
  logic [DATA_WIDTH-1:0] hold_data_q [PORT_NUM];
  logic [DATA_WIDTH-1:0] hold_data_d [PORT_NUM];

  logic [1:0]            cnt_q, cnt_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [PORT_W-1:0]     fifo_port_q [2];
  logic [PORT_W-1:0]     fifo_port_d [2];
  logic                  fifo_last_q [2];
  logic                  fifo_last_d [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];

  logic [PORT_NUM-1:0]   take;
  logic [PORT_NUM-1:0]   load;
  logic [PORT_W-1:0]     sel;
  logic                  fifo_ok;
  logic                  push;
  logic                  pop;
  logic [PORT_NUM-1:0]   gnt_exp;

  // Port selection: arbiter choice in ARB, sticky port in LOCK
  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    take        = '0;
    arb_round   = 1'b0;
    fifo_ok     = (cnt_q < 2'd2);
    sel         = (state_q == ST_LOCK) ? lock_port_q : arb_port;
    unique case (state_q)
      ST_ARB: begin
        if ((|hold_vld_q) && fifo_ok && hold_vld_q[sel]) begin
          take[sel] = 1'b1;
          arb_round = 1'b1;
          if (!hold_last_q[sel]) begin
            state_d     = ST_LOCK;
            lock_port_d = sel;
          end
        end
      end
      ST_LOCK: begin
        if (hold_vld_q[sel] && fifo_ok) begin
          take[sel] = 1'b1;
          if (hold_last_q[sel]) begin
            state_d = ST_ARB;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign in_rdy  = ~hold_vld_q | take;
  assign arb_req = hold_vld_q;
  assign push    = |take;
  assign pop     = out_vld & out_rdy;

  // A take and a load in the same cycle keeps the register full with the new beat
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      load[i]        = in_vld[i] & in_rdy[i];
      hold_vld_d[i]  = load[i] | (hold_vld_q[i] & ~take[i]);
      hold_last_d[i] = load[i] ? in_last[i] : hold_last_q[i];
      hold_data_d[i] = load[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : hold_data_q[i];
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    for (int e = 0; e < 2; e++) begin
      fifo_port_d[e] = fifo_port_q[e];
      fifo_last_d[e] = fifo_last_q[e];
      fifo_data_d[e] = fifo_data_q[e];
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push) begin
      fifo_port_d[wr_ptr_q] = sel;
      fifo_last_d[wr_ptr_q] = hold_last_q[sel];
      fifo_data_d[wr_ptr_q] = hold_data_q[sel];
    end
  end

  assign out_vld  = (cnt_q != 2'd0);
  assign out_last = fifo_last_q[rd_ptr_q];
  assign out_port = fifo_port_q[rd_ptr_q];
  assign out_data = fifo_data_q[rd_ptr_q];
  assign busy     = (state_q == ST_LOCK) | (|hold_vld_q) | (cnt_q != 2'd0);

  // Control and FIFO state; FIFO entries are cleared so out_* read zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      lock_port_q <= '0;
      hold_vld_q  <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        fifo_port_q[e] <= '0;
        fifo_last_q[e] <= 1'b0;
        fifo_data_q[e] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      hold_vld_q  <= hold_vld_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      for (int e = 0; e < 2; e++) begin
        fifo_port_q[e] <= fifo_port_d[e];
        fifo_last_q[e] <= fifo_last_d[e];
        fifo_data_q[e] <= fifo_data_d[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    hold_last_q <= hold_last_d;
    for (int i = 0; i < PORT_NUM; i++) begin
      hold_data_q[i] <= hold_data_d[i];
    end
  end

  assign gnt_exp = {{(PORT_NUM-1){1'b0}}, 1'b1} << arb_port;

  gnt_matches_port: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == ST_ARB) && (|hold_vld_q)) |-> (arb_gnt == gnt_exp));

endmodule
